// File: rtl/mul_writeback_seq.sv
// Sequencer around multiply_unit: issues UMULL/SMULL operands, waits the multiply
// latency, then writes the 32-bit product to the register file as lo/hi halves.
module mul_writeback_seq #(
    parameter int MUL_LATENCY = 1,
    parameter int REG_ADDR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [15:0]           req_a,
    input  logic [15:0]           req_b,
    input  logic                  req_signed,
    input  logic [REG_ADDR_W-1:0] req_rd_lo,
    input  logic [REG_ADDR_W-1:0] req_rd_hi,
    output logic [15:0]           mul_operand_a,
    output logic [15:0]           mul_operand_b,
    output logic                  mul_is_signed,
    input  logic [15:0]           mul_result_lo,
    input  logic [15:0]           mul_result_hi,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [15:0]           wr_data,
    input  logic                  wr_ack,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, MUL, WB_LO, WB_HI} state_t;

    localparam logic [2:0] LAT_LOAD = 3'(MUL_LATENCY);

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [REG_ADDR_W-1:0]   rd_lo_q, rd_lo_d;
    logic [REG_ADDR_W-1:0]   rd_hi_q, rd_hi_d;
    logic [31:0]             prod_q, prod_d;
    logic [15:0]             op_a_q, op_a_d;
    logic [15:0]             op_b_q, op_b_d;
    logic                    signed_q, signed_d;
    logic                    wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]             wr_data_q, wr_data_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rd_lo_q   <= '0;
            rd_hi_q   <= '0;
            prod_q    <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            signed_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_lo_q   <= rd_lo_d;
            rd_hi_q   <= rd_hi_d;
            prod_q    <= prod_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            signed_q  <= signed_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_lo_d   = rd_lo_q;
        rd_hi_d   = rd_hi_q;
        prod_d    = prod_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        signed_d  = signed_q;
        wr_en_d   = wr_en_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && !flush) begin
                    op_a_d   = req_a;
                    op_b_d   = req_b;
                    signed_d = req_signed;
                    rd_lo_d  = req_rd_lo;
                    rd_hi_d  = req_rd_hi;
                    cnt_d    = LAT_LOAD;
                    state_d  = MUL;
                end
            end
            MUL: begin
                if (cnt_q == 3'd0) begin
                    prod_d  = {mul_result_hi, mul_result_lo};
                    wr_en_d = 1'b1;
                    // Same destination for both halves: only the hi write survives.
                    if (rd_lo_q == rd_hi_q) begin
                        wr_addr_d = rd_hi_q;
                        wr_data_d = mul_result_hi;
                        state_d   = WB_HI;
                    end else begin
                        wr_addr_d = rd_lo_q;
                        wr_data_d = mul_result_lo;
                        state_d   = WB_LO;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            WB_LO: begin
                if (wr_ack) begin
                    wr_addr_d = rd_hi_q;
                    wr_data_d = prod_q[31:16];
                    state_d   = WB_HI;
                end
            end
            WB_HI: begin
                if (wr_ack) begin
                    wr_en_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons any unwritten half; an already-acked lo write stands.
        if (flush) begin
            state_d = IDLE;
            wr_en_d = 1'b0;
            done_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    assign req_ready     = (state_q == IDLE);
    assign mul_operand_a = op_a_q;
    assign mul_operand_b = op_b_q;
    assign mul_is_signed = signed_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_mul_writeback_seq.sv
// Bench for mul_writeback_seq: behavioural multiply_unit plus a write scoreboard.
module tb_mul_writeback_seq;

    localparam int LAT = 1;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [15:0]   req_a = '0;
    logic [15:0]   req_b = '0;
    logic          req_signed = 1'b0;
    logic [AW-1:0] req_rd_lo = '0;
    logic [AW-1:0] req_rd_hi = '0;
    logic [15:0]   mul_operand_a, mul_operand_b;
    logic          mul_is_signed;
    logic [15:0]   mul_result_lo, mul_result_hi;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_ack = 1'b1;
    logic          busy, done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [19:0] exp_q[$];
    logic [31:0] mul_pipe[LAT];

    mul_writeback_seq #(.MUL_LATENCY(LAT), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_signed(req_signed),
        .req_rd_lo(req_rd_lo), .req_rd_hi(req_rd_hi),
        .mul_operand_a(mul_operand_a), .mul_operand_b(mul_operand_b),
        .mul_is_signed(mul_is_signed),
        .mul_result_lo(mul_result_lo), .mul_result_hi(mul_result_hi),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic s);
        logic signed [31:0] sa, sb;
        if (s) begin
            sa = {{16{a[15]}}, a};
            sb = {{16{b[15]}}, b};
            return 32'(sa * sb);
        end
        return {16'h0, a} * {16'h0, b};
    endfunction

    // multiply_unit model: LAT register stages from operands to result
    always_ff @(posedge clk) begin
        mul_pipe[0] <= ref_mul(mul_operand_a, mul_operand_b, mul_is_signed);
        for (int i = 1; i < LAT; i++) mul_pipe[i] <= mul_pipe[i-1];
    end
    assign {mul_result_hi, mul_result_lo} = mul_pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Every accepted write is compared with the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && wr_en && wr_ack) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("wr_addr_data", {12'h0, wr_addr, wr_data}, {12'h0, exp_q.pop_front()});
        end
        if (rst_n && done) done_cnt++;
    end

    task automatic expect_wr(input logic [AW-1:0] addr, input logic [15:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic expect_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                             input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        logic [31:0] p;
        p = ref_mul(a, b, s);
        if (lo != hi) expect_wr(lo, p[15:0]);
        expect_wr(hi, p[31:16]);
    endtask

    // Presents a request for exactly one edge; caller ensures the sequencer is idle.
    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [AW-1:0] lo, input logic [AW-1:0] hi);
        req_a = a; req_b = b; req_signed = s; req_rd_lo = lo; req_rd_hi = hi;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int d0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_op_a", 32'(mul_operand_a), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // UMULL 0xFFFF*0xFFFF with cycle-exact timing
        expect_op(16'hFFFF, 16'hFFFF, 1'b0, 4'd2, 4'd3);
        issue(16'hFFFF, 16'hFFFF, 1'b0, 4'd2, 4'd3);
        chk("t1_e0_ready", 32'(req_ready), 32'd0);
        chk("t1_e0_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        chk("t1_e1_wr_en", 32'(wr_en), 32'd0);
        chk("t1_e1_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("t1_e2_wr", {15'h0, wr_en, wr_addr, wr_data[11:0]}, {15'h0, 1'b1, 4'd2, 12'h001});
        chk("t1_e2_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("t1_e3_wr", {11'h0, wr_en, wr_addr, wr_data}, {11'h0, 1'b1, 4'd3, 16'hFFFE});
        chk("t1_e3_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("t1_e4_done", 32'(done), 32'd1);
        chk("t1_e4_ready", 32'(req_ready), 32'd1);
        chk("t1_e4_wr_en", 32'(wr_en), 32'd0);
        @(posedge clk); #1;
        chk("t1_done_pulse", 32'(done), 32'd0);
        wait_idle();
        chk("t1_op_hold", {mul_operand_a, mul_operand_b}, 32'hFFFFFFFF);

        // SMULL -100 * 200
        expect_wr(4'd4, 16'hB1E0);
        expect_wr(4'd5, 16'hFFFF);
        issue(16'hFF9C, 16'd200, 1'b1, 4'd4, 4'd5);
        wait_idle();

        // wr_ack stalled for three cycles in WB_LO
        d0 = done_cnt;
        wr_ack = 1'b0;
        expect_wr(4'd1, 16'h0023);
        expect_wr(4'd6, 16'h0000);
        issue(16'd5, 16'd7, 1'b0, 4'd1, 4'd6);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_hold", {11'h0, wr_en, wr_addr, wr_data}, {11'h0, 1'b1, 4'd1, 16'h0023});
            if (i < 2) begin
                @(posedge clk); #1;
            end
        end
        wr_ack = 1'b1;
        wait_idle();
        chk("t3_one_done", done_cnt - d0, 32'd1);

        // Same destination: only the hi half is written
        expect_wr(4'd7, 16'h0002);
        issue(16'h0100, 16'h0200, 1'b0, 4'd7, 4'd7);
        wait_idle();

        // Flush in MUL discards the request
        issue(16'd3, 16'd4, 1'b1, 4'd8, 4'd9);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("t5_flush_busy", 32'(busy), 32'd0);
        chk("t5_flush_wr_en", 32'(wr_en), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        // Flush in IDLE blocks a simultaneous request
        req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        chk("t5_idle_flush_block", 32'(busy), 32'd0);
        expect_op(16'hFFFB, 16'hFFF9, 1'b1, 4'd10, 4'd11);
        issue(16'hFFFB, 16'hFFF9, 1'b1, 4'd10, 4'd11);
        wait_idle();

        // Async reset in WB_HI: lo already written, hi never
        expect_wr(4'd12, 16'h0006);
        issue(16'd2, 16'd3, 1'b0, 4'd12, 4'd13);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_in_wb_hi", {27'h0, wr_en, wr_addr}, {27'h0, 1'b1, 4'd13});
        rst_n = 1'b0;
        #1;
        chk("t6_rst_wr_en", 32'(wr_en), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_op(16'h1234, 16'h0010, 1'b0, 4'd14, 4'd15);
        issue(16'h1234, 16'h0010, 1'b0, 4'd14, 4'd15);
        wait_idle();

        chk("total_done", done_cnt, 32'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
